// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_reg #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm32,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              stall_req,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm32,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic load_in_ex;
    logic rs_dep;
    logic rt_dep;
    logic hazard;
    logic bubble;

    // A load in EX whose destination the ID instruction reads; r0 never forwards a hazard.
    assign load_in_ex = ex_valid && ex_mem_read && ex_reg_write && (ex_rt != 5'd0);
    assign rs_dep     = id_uses_rs && (id_rs == ex_rt);
    assign rt_dep     = id_uses_rt && (id_rt == ex_rt);
    assign hazard     = load_in_ex && id_valid && (rs_dep || rt_dep);
    assign stall_req  = hazard && !ext_stall;
    assign bubble     = flush || stall_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_pc        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm32     <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_ctrl      <= '0;
            ex_valid     <= 1'b0;
            bubble_cnt   <= '0;
        end else if (!ext_stall) begin
            // Data and index fields always follow ID; only the control side is squashed.
            ex_pc      <= id_pc;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm32   <= id_imm32;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            if (bubble) begin
                ex_mem_read  <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_ctrl      <= '0;
                ex_valid     <= 1'b0;
                if (bubble_cnt != {CNT_W{1'b1}}) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end else begin
                ex_mem_read  <= id_valid && id_mem_read;
                ex_reg_write <= id_valid && id_reg_write;
                ex_ctrl      <= id_valid ? id_ctrl : '0;
                ex_valid     <= id_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - self-checking bench for id_ex_reg
module tb_id_ex_reg;

    localparam int CTRL_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic [31:0]       id_pc, id_rs_data, id_rt_data, id_imm32;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt, id_mem_read, id_reg_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_valid, ext_stall, flush;
    logic              stall_req;
    logic [31:0]       ex_pc, ex_rs_data, ex_rt_data, ex_imm32;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_mem_read, ex_reg_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_valid;
    logic [CNT_W-1:0]  bubble_cnt;

    id_ex_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .id_ctrl(id_ctrl), .id_valid(id_valid), .ext_stall(ext_stall), .flush(flush),
        .stall_req(stall_req),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm32(ex_imm32),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       pc, rs_data, rt_data, imm;
        logic [4:0]        rs, rt, rd;
        logic              mr, rw, valid;
        logic [CTRL_W-1:0] ctrl;
        int                cnt;
        bit                known;
        bit                init;
    } ex_t;

    ex_t m;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The instruction in EX is a load whose destination the ID instruction needs.
    function automatic bit model_hazard();
        if (!(m.valid && m.mr && m.rw && m.rt != 5'd0 && id_valid)) return 1'b0;
        return (id_uses_rs && id_rs == m.rt) || (id_uses_rt && id_rt == m.rt);
    endfunction

    task automatic step();
        bit hz;
        #1;
        hz = !ext_stall && model_hazard();
        if (m.init) chk("stall_req", 32'(stall_req), 32'(hz));
        if (!rst_n) begin
            m = '{default: 0};
            m.init  = 1'b1;
            m.known = 1'b1;
        end else if (ext_stall) begin
            m.init = m.init;
        end else if (flush || hz) begin
            m.valid = 1'b0;
            m.mr    = 1'b0;
            m.rw    = 1'b0;
            m.ctrl  = '0;
            m.known = 1'b0;
            if (m.cnt < CNT_MAX) m.cnt++;
        end else begin
            m.pc      = id_pc;
            m.rs_data = id_rs_data;
            m.rt_data = id_rt_data;
            m.imm     = id_imm32;
            m.rs      = id_rs;
            m.rt      = id_rt;
            m.rd      = id_rd;
            m.valid   = id_valid;
            m.mr      = id_valid & id_mem_read;
            m.rw      = id_valid & id_reg_write;
            m.ctrl    = id_valid ? id_ctrl : '0;
            m.known   = 1'b1;
        end
        @(posedge clk);
        #1;
        if (m.init) begin
            chk("ex_valid", 32'(ex_valid), 32'(m.valid));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
            chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(m.cnt));
            if (m.known) begin
                chk("ex_pc", ex_pc, m.pc);
                chk("ex_rs_data", ex_rs_data, m.rs_data);
                chk("ex_rt_data", ex_rt_data, m.rt_data);
                chk("ex_imm32", ex_imm32, m.imm);
                chk("ex_idx", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m.rs, m.rt, m.rd});
            end
        end
    endtask

    task automatic rand_inputs();
        id_pc        = $urandom;
        id_rs_data   = $urandom;
        id_rt_data   = $urandom;
        id_imm32     = $urandom;
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_rd        = 5'($urandom_range(0, 3));
        id_uses_rs   = 1'($urandom);
        id_uses_rt   = 1'($urandom);
        id_mem_read  = 1'($urandom);
        id_reg_write = 1'($urandom);
        id_ctrl      = CTRL_W'($urandom);
        id_valid     = 1'($urandom);
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urs, input logic urt,
                             input logic mr, input logic rw, input logic [CTRL_W-1:0] ctrl);
        rand_inputs();
        id_pc        = pc;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_mem_read  = mr;
        id_reg_write = rw;
        id_ctrl      = ctrl;
        id_valid     = 1'b1;
        rst_n        = 1'b1;
        ext_stall    = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        m = '{default: 0};
        rand_inputs();
        ext_stall = 1'($urandom);
        flush     = 1'($urandom);
        rst_n     = 1'b0;
        step();
        rand_inputs();
        step();
        #1;
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_cnt", 32'(bubble_cnt), 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_valid", 32'(ex_valid), 32'd0);

        // plain load into EX
        set_instr(32'h00400010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A3);
        id_imm32 = 32'hFFFF8000;
        step();
        chk("plain_pc", ex_pc, 32'h00400010);
        chk("plain_imm", ex_imm32, 32'hFFFF8000);
        chk("plain_rd", 32'(ex_rd), 32'd5);
        chk("plain_ctrl", 32'(ex_ctrl), 32'h00A3);
        chk("plain_valid", 32'(ex_valid), 32'd1);

        // load-use on rs
        set_instr(32'h100, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h104, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
        #1 chk("lu_stall", 32'(stall_req), 32'd1);
        step();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        chk("lu_cnt", 32'(bubble_cnt), 32'd1);
        chk("lu_stall_drop", 32'(stall_req), 32'd0);
        step();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rs", 32'(ex_rs), 32'd8);

        // r0 destination is never a hazard
        set_instr(32'h200, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h204, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
        #1 chk("r0_stall", 32'(stall_req), 32'd0);
        step();
        chk("r0_cnt", 32'(bubble_cnt), 32'd1);

        // no source operands used
        set_instr(32'h300, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h304, 5'd8, 5'd8, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0022);
        #1 chk("nouse_stall", 32'(stall_req), 32'd0);
        step();
        chk("nouse_cnt", 32'(bubble_cnt), 32'd1);

        // store reading the loaded register through rt
        set_instr(32'h400, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h404, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0044);
        #1 chk("store_stall", 32'(stall_req), 32'd1);
        step();
        chk("store_cnt", 32'(bubble_cnt), 32'd2);
        step();

        // flush together with a hazard: a single bubble
        set_instr(32'h500, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h504, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
        flush = 1'b1;
        step();
        chk("flush_hz_cnt", 32'(bubble_cnt), 32'd3);
        chk("flush_hz_valid", 32'(ex_valid), 32'd0);

        // external stall beats flush and hazard
        set_instr(32'h600, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
        step();
        set_instr(32'h604, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
        ext_stall = 1'b1;
        flush     = 1'b1;
        #1 chk("xs_stall", 32'(stall_req), 32'd0);
        step();
        chk("xs_cnt", 32'(bubble_cnt), 32'd3);
        chk("xs_hold_valid", 32'(ex_valid), 32'd1);
        chk("xs_hold_pc", ex_pc, 32'h600);

        // reset while stalled
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(ex_valid), 32'd0);
        chk("midrst_cnt", 32'(bubble_cnt), 32'd0);
        chk("midrst_pc", ex_pc, 32'd0);

        // saturation after more bubbles than the counter can hold
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            set_instr(32'h700, 5'd3, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
            step();
            set_instr(32'h704, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
            step();
        end
        chk("sat_cnt", 32'(bubble_cnt), 32'(CNT_MAX));

        // randomized traffic against the reference model
        rand_inputs();
        rst_n = 1'b0;
        ext_stall = 1'b0;
        flush = 1'b0;
        step();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst_n     = ($urandom_range(0, 39) != 0);
            ext_stall = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register directly downstream of the immediate extender and register file.
- Captures the decoded instruction bundle (PC, rs/rt data, 32-bit extended immediate, register indices, control word) at the ID->EX boundary.
- Detects load-use hazards against the instruction already in EX and inserts bubbles.
- Handles external stall and flush, and keeps a saturating bubble counter for debug.

Parameters:
- CTRL_W, 16, width of the opaque EX/MEM/WB control word carried through.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_pc  in  32  PC of the ID instruction.
- id_rs_data  in  32  rs read data.
- id_rt_data  in  32  rt read data.
- id_imm32  in  32  extended immediate from the extender.
- id_rs  in  5  rs index.
- id_rt  in  5  rt index.
- id_rd  in  5  rd index.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_mem_read  in  1  ID instruction is a load.
- id_reg_write  in  1  ID instruction writes a register.
- id_ctrl  in  CTRL_W  remaining control word.
- id_valid  in  1  ID holds a real instruction.
- ext_stall  in  1  downstream stall (MEM wait): hold EX contents.
- flush  in  1  squash the ID instruction (branch/jump redirect from EX).
- stall_req  out  1  load-use hazard: IF and IF/ID must hold.
- ex_pc, ex_rs_data, ex_rt_data, ex_imm32  out  32 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  5 each  registered indices.
- ex_mem_read, ex_reg_write  out  1 each  registered control bits.
- ex_ctrl  out  CTRL_W  registered control word.
- ex_valid  out  1  EX holds a real instruction.
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All ex_* outputs, ex_valid and bubble_cnt go to 0.
  - Reset overrides every other input, including when it arrives mid-stall or mid-hazard.
- stall_req is combinational and asserts when all of the following hold:
  - ex_valid and ex_mem_read and ex_reg_write, and ex_rt != 0;
  - id_valid;
  - (id_uses_rs and id_rs == ex_rt) or (id_uses_rt and id_rt == ex_rt).
- stall_req is forced to 0 while ext_stall=1. In that case EX holds, so the hazard is re-evaluated after the stall releases.
- Per-cycle update, in priority order:
  1. ext_stall=1: all ex_* registers hold; bubble_cnt holds.
  2. flush=1: bubble. ex_valid, ex_mem_read, ex_reg_write and ex_ctrl go to 0; the data and index fields may take ID values (don't care). Flush wins over a simultaneous hazard.
  3. stall_req=1: bubble, same as flush. The ID instruction is not lost because IF/ID holds it.
  4. Otherwise, load:
     - all ID fields are copied;
     - ex_valid=id_valid;
     - when id_valid=0, ex_mem_read, ex_reg_write and ex_ctrl load as 0.
- Bubble counting:
  - Cases 2 and 3 increment bubble_cnt by 1.
  - The counter saturates at all-ones and never wraps.
  - id_valid=0 loads (case 4) do not count.
- Latency: one cycle from ID inputs to ex_* outputs. A load-use pair costs exactly one bubble: in the second cycle EX holds the bubble and stall_req drops.
- r0 is never a hazard source (ex_rt==0 suppresses stall_req).
- A store's rt read after a load to the same rt stalls, because id_uses_rt=1.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with random inputs -> all outputs 0, bubble_cnt=0, stall_req=0.
- Plain load: id_pc=0x00400010, id_imm32=0xFFFF8000, id_rd=5, id_ctrl=0x00A3, id_valid=1 -> next cycle ex_pc=0x00400010, ex_imm32=0xFFFF8000, ex_rd=5, ex_ctrl=0x00A3, ex_valid=1.
- Load-use on rs:
  - Setup: EX holds lw with ex_rt=8, mem_read=1, reg_write=1. ID holds add with id_rs=8, id_uses_rs=1.
  - Required: stall_req=1 in the same cycle; next cycle ex_valid=0, bubble_cnt=1, stall_req=0.
  - Following cycle: the add loads.
- Hazard suppressed:
  - Same setup with ex_rt=0 -> stall_req=0, no bubble.
  - Same setup with id_uses_rs=0 and id_uses_rt=0 -> stall_req=0, no bubble.
- Flush + hazard:
  - Hazard condition and flush=1 together -> one bubble, bubble_cnt+1 (not +2).
  - ext_stall=1 with flush=1 -> EX holds, stall_req=0, bubble_cnt unchanged.
- Saturation: force 2^CNT_W+3 hazard bubbles (CNT_W=4 build) -> bubble_cnt stops at 0xF.
- Mid-operation reset: rst_n=0 during ext_stall -> outputs 0 next cycle.
